one_to_four_demux: RTL and testbench
====================================

ONE_TO_FOUR_DEMUX -- requirements
Module: one_to_four_demux

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, data width of input and each output lane.
REQ-002 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: in  input  WIDTH  input data beat.
REQ-005 SHALL provide port: in_valid  input  1  input beat present.
REQ-006 SHALL provide port: in_ready  output  1  block can accept the beat this cycle.
REQ-007 SHALL provide ports: s0, s1  input  1 each  lane select; {s1,s0}=0..3 selects a, b, c, d.
REQ-008 SHALL provide ports: a, b, c, d  output  WIDTH each  lane data.
REQ-009 SHALL provide ports: a_valid, b_valid, c_valid, d_valid  output  1 each  lane data valid.
REQ-010 SHALL provide ports: a_ready, b_ready, c_ready, d_ready  input  1 each  lane consumer ready.
REQ-011 SHALL provide port: busy  output  1  OR of all lane valids.

Function
REQ-012 SHALL hold one registered entry (data + valid) per lane; no combinational path from in to any lane output.
REQ-013 SHALL define the target lane as {s1,s0}, sampled in the cycle of acceptance only; select may change freely in any other cycle.
REQ-014 SHALL drive in_ready = !target_valid || target_ready, combinationally from the current target lane.
REQ-015 SHALL accept a beat when in_valid && in_ready; data appears on the target lane with valid=1 on the next rising edge (latency 1 cycle).
REQ-016 SHALL consume a lane entry when lane_valid && lane_ready; valid clears on the next edge unless refilled in the same cycle.
REQ-017 SHALL, on simultaneous consume and accept on the same lane, load the new beat and keep lane_valid=1 (no bubble).
REQ-018 SHALL hold lane data and valid stable while lane_valid && !lane_ready.
REQ-019 SHALL allow independent lanes to drain concurrently with an accept to a different lane in the same cycle.
REQ-020 SHALL never write a non-target lane; a lane's data register changes only on acceptance into that lane.
REQ-021 SHALL ignore in when in_valid=0; in_ready value is don't-care to state when in_valid=0.
REQ-022 SHALL drive busy combinationally from the four lane valid registers.

Reset
REQ-023 SHALL, on rst_n low, immediately clear all lane valids and lane data to 0, busy to 0, and round-robin pointer (if present) to 0.
REQ-024 SHALL drive in_ready=1 during and directly after reset (all lanes empty).
REQ-025 SHALL discard any in-flight beat on reset mid-operation; no beat is delivered after rst_n rises unless newly accepted.

Configuration
REQ-026 SHALL, when macro ONE_TO_FOUR_DEMUX_RR_EN is defined, replace {s1,s0} as target by an internal 2-bit pointer that starts at 0 and increments by 1 on each accepted beat, wrapping 3->0; s0, s1 remain ports but are ignored.
REQ-027 SHALL, in RR mode, not advance the pointer when no beat is accepted (including when in_valid=1 and in_ready=0).
REQ-028 SHALL, without ONE_TO_FOUR_DEMUX_RR_EN, contain no pointer logic and use {s1,s0} as in REQ-013.

Verification
REQ-029 SHALL cover: reset, {s1,s0}=2, in=8'hA5 valid 1 cycle, all readys=1 -> c=8'hA5, c_valid=1 exactly one cycle later, other lanes valid=0.
REQ-030 SHALL cover: {s1,s0}=0, a_ready=0, send 8'h11 then 8'h22 -> a=8'h11 held, in_ready=0 on second beat; raise a_ready -> 8'h22 loaded same edge 8'h11 consumed, a_valid stays 1.
REQ-031 SHALL cover: a full with a_ready=0, select switched to 3, send 8'h33 -> in_ready=1, d=8'h33 next cycle, a unchanged.
REQ-032 SHALL cover: lanes b and c full, rst_n pulsed low mid-cycle -> all valids and busy 0 immediately without clock edge, in_ready=1.
REQ-033 SHALL cover (RR_EN): six beats 8'h01..8'h06, all readys=1, s0/s1 toggling -> lanes a,b,c,d,a,b receive them in order; pointer wraps 3->0.
REQ-034 SHALL cover (RR_EN): b_ready=0 with b full when pointer=1 -> in_ready=0, pointer holds at 1 for 5 cycles of in_valid=1, advances only after acceptance.

Source files
------------

// File: rtl/one_to_four_demux.sv
// Routes each accepted input beat into one of four single-entry lane registers (a..d).
// Latency: 1 cycle from acceptance to lane valid. Backpressure: in_ready follows only the target lane.
// Define ONE_TO_FOUR_DEMUX_RR_EN to pick lanes round-robin instead of from {s1,s0}.
module one_to_four_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic             busy
);

  logic [3:0]            vld_q, vld_d;
  logic [3:0][WIDTH-1:0] dat_q, dat_d;
  logic [3:0]            lane_rdy;
  logic [1:0]            tgt;
  logic                  accept;

  assign lane_rdy = {d_ready, c_ready, b_ready, a_ready};

`ifdef ONE_TO_FOUR_DEMUX_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_sel;

  // Select pins stay on the boundary but carry no meaning in this mode.
  assign unused_sel = s0 ^ s1;
  assign tgt        = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign tgt = {s1, s0};
`endif

  assign in_ready = !vld_q[tgt] || lane_rdy[tgt];
  assign accept   = in_valid && in_ready;

  // Drain every lane first, then let the accepted beat refill its lane so a
  // same-cycle consume + accept leaves the lane valid without a bubble.
  always_comb begin
    vld_d = vld_q & ~lane_rdy;
    dat_d = dat_q;
    if (accept) begin
      vld_d[tgt] = 1'b1;
      dat_d[tgt] = in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign a       = dat_q[0];
  assign b       = dat_q[1];
  assign c       = dat_q[2];
  assign d       = dat_q[3];
  assign a_valid = vld_q[0];
  assign b_valid = vld_q[1];
  assign c_valid = vld_q[2];
  assign d_valid = vld_q[3];
  assign busy    = |vld_q;

endmodule

// File: tb/tb_one_to_four_demux.sv
// Directed bench for one_to_four_demux with a lane scoreboard; RR scenarios
// are included when ONE_TO_FOUR_DEMUX_RR_EN is defined.
module tb_one_to_four_demux;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] dat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_dat;
  logic       in_valid;
  logic       in_ready;
  logic       s0, s1;
  logic [7:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  exp_t       sbq[$];
  logic [7:0] last_dat [4];
  logic [1:0] mptr;

  wire [3:0]      vld_o = {d_valid, c_valid, b_valid, a_valid};
  wire [3:0]      rdy_v = {d_ready, c_ready, b_ready, a_ready};
  wire [3:0][7:0] dat_o = {d, c, b, a};

  one_to_four_demux #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_lane(input int lane);
    for (int k = 0; k < sbq.size(); k++) begin
      if (int'(sbq[k].lane) == lane) return k;
    end
    return -1;
  endfunction

  function automatic logic [1:0] model_tgt();
`ifdef ONE_TO_FOUR_DEMUX_RR_EN
    return mptr;
`else
    return {s1, s0};
`endif
  endfunction

  task automatic model_reset();
    sbq.delete();
    for (int i = 0; i < 4; i++) last_dat[i] = 8'h00;
    mptr = 2'd0;
  endtask

  // Compare every lane against the model, retire consumed entries, record the
  // accepted beat, then advance one clock and settle 1 ns past the edge.
  task automatic tick();
    int         idx;
    logic [1:0] t;
    logic       exp_rdy;
    for (int i = 0; i < 4; i++) begin
      idx = find_lane(i);
      chk($sformatf("lane%0d_valid", i), {31'd0, vld_o[i]}, {31'd0, idx >= 0});
      chk($sformatf("lane%0d_data", i), {24'd0, dat_o[i]}, {24'd0, last_dat[i]});
    end
    chk("busy", {31'd0, busy}, {31'd0, sbq.size() != 0});
    t       = model_tgt();
    exp_rdy = (find_lane(int'(t)) < 0) || rdy_v[t];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      idx = find_lane(i);
      if (idx >= 0 && rdy_v[i]) begin
        chk($sformatf("lane%0d_pop", i), {24'd0, dat_o[i]}, {24'd0, sbq[idx].dat});
        sbq.delete(idx);
      end
    end
    if (in_valid && exp_rdy) begin
      sbq.push_back('{lane: t, dat: in_dat});
      last_dat[t] = in_dat;
      mptr        = mptr + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] v);
    {s1, s0} = sel;
    in_dat   = v;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_dat = 8'h00; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
    {d_ready, c_ready, b_ready, a_ready} = 4'hF;
    model_reset();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valids", {28'd0, vld_o}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single beat to lane c with every consumer ready.
    send(2'd2, 8'hA5);
    chk("c_after_1", {24'd0, c}, 32'hA5);
    chk("c_valid_after_1", {31'd0, c_valid}, 32'd1);
    chk("others_idle", {28'd0, vld_o & 4'b1011}, 32'd0);
    tick();
    chk("c_drained", {31'd0, c_valid}, 32'd0);

    // Lane a backpressured: second beat stalls, then refills on the consume edge.
    a_ready = 1'b0;
    send(2'd0, 8'h11);
    {s1, s0} = 2'd0; in_dat = 8'h22; in_valid = 1'b1; #1;
    chk("a_full_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("a_held", {24'd0, a}, 32'h11);
    a_ready = 1'b1; #1;
    tick();
    in_valid = 1'b0; a_ready = 1'b0;
    chk("a_refilled", {24'd0, a}, 32'h22);
    chk("a_no_bubble", {31'd0, a_valid}, 32'd1);

    // Blocked lane a must not stall a beat aimed at lane d.
    {s1, s0} = 2'd3; in_dat = 8'h33; in_valid = 1'b1; #1;
    chk("d_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("d_loaded", {24'd0, d}, 32'h33);
    chk("a_untouched", {24'd0, a}, 32'h22);
    tick();

    // Drain a while accepting into b; idle input with junk data is ignored.
    a_ready = 1'b1;
    send(2'd1, 8'h5A);
    in_dat = 8'hFF; s0 = 1'b1;
    tick(); tick();

    // Mid-cycle reset with b and c full.
    b_ready = 1'b0; c_ready = 1'b0;
    send(2'd1, 8'h44);
    send(2'd2, 8'h55);
    tick();
    chk("b_c_full", {28'd0, vld_o}, 32'b0110);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {28'd0, vld_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_data", {dat_o[3], dat_o[2], dat_o[1], dat_o[0]}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    {d_ready, c_ready, b_ready, a_ready} = 4'hF;
    tick(); tick();

`ifdef ONE_TO_FOUR_DEMUX_RR_EN
    // Six beats land on a,b,c,d,a,b regardless of the select pins.
    for (int i = 1; i <= 6; i++) begin
      send(2'(i * 3), 8'(i));
      chk($sformatf("rr_beat%0d", i), {24'd0, dat_o[(i - 1) % 4]}, i);
    end
    tick();
    // Fill b, walk the pointer round to it, then hold a stalled beat.
    b_ready = 1'b0;
    send(2'd0, 8'h70);
    send(2'd0, 8'h71);
    send(2'd0, 8'h72);
    send(2'd0, 8'h80);
    send(2'd0, 8'h81);
    send(2'd0, 8'h82);
    send(2'd0, 8'h83);
    in_dat = 8'h90; in_valid = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    b_ready = 1'b1; #1;
    tick();
    in_valid = 1'b0;
    chk("rr_b_loaded", {24'd0, b}, 32'h90);
    send(2'd1, 8'h91);
    chk("rr_after_stall_c", {24'd0, c}, 32'h91);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
